mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
Sequencing stage directly upstream of the 4x1 1-bit multiplexer. Drives the mux select lines s1/s2 through all four channels, waits a programmable settle time on each, and samples the mux output e. Assembles the four samples into a 4-bit word and hands it downstream with a valid/ready handshake.

Parameters:
SETTLE, 1, idle cycles per channel between select change and sample; legal range 0..15.
CW, 4, settle counter width; must hold SETTLE.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request one scan of channels 0..3; sampled only in IDLE, or in DONE during handshake
e  input  1  mux output for the currently selected channel
s1  output  1  select bit 0 to the mux (channel index bit 0)
s2  output  1  select bit 1 to the mux (channel index bit 1)
word  output  4  scan result; word[i] = e sampled with channel i selected
valid  output  1  word holds a completed scan
ready  input  1  downstream accepts word when valid & ready
busy  output  1  high in SCAN and DONE

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Channel mapping: channel = {s2,s1}.
  - 0 selects a.
  - 1 selects b (s1=1).
  - 2 selects c (s2=1).
  - 3 selects d.
- Reset, async assert, all registers cleared immediately:
  - state=IDLE, ch=0, cnt=0, shadow=0.
  - s1=0, s2=0, word=0, valid=0, busy=0.
- All outputs are registered. s1/s2 reflect ch at all times and show 0 in IDLE.
- States: IDLE, SCAN, DONE. Encoding is 2 bits; 2'b11 is illegal and recovers to IDLE.
- IDLE:
  - start=1 -> SCAN with ch=0, cnt=SETTLE.
  - Otherwise stay in IDLE.
- SCAN:
  - If cnt!=0: cnt-=1.
  - If cnt==0: shadow[ch] <= e.
    - If ch==3: word <= {e, shadow[2:0]}, valid <= 1, go to DONE.
    - Otherwise: ch+=1, cnt=SETTLE.
  - Each channel is held for exactly SETTLE+1 cycles. The sample is taken at the end of the last cycle of that window.
- Latency: valid rises 4*(SETTLE+1) cycles after the edge that accepts start.
  - SETTLE=1: 8 cycles.
  - SETTLE=0: 4 cycles.
- SCAN ignores start. No queuing: a start asserted during SCAN is lost.
- DONE:
  - valid=1 and word held stable. ch stays 3, so s1=s2=1.
  - ready=1 completes the handshake:
    - valid <= 0.
    - If start=1 in the same cycle, go directly to SCAN (ch=0, cnt=SETTLE), with no IDLE bubble.
    - Otherwise go to IDLE.
  - ready=0: hold indefinitely.
- word changes only on the DONE entry edge and otherwise keeps its last scan, including after return to IDLE.
- Reset mid-scan: the scan is aborted, no valid is produced, and word returns to 0.
- ready is ignored outside DONE.

Decomposition:
- Shared package:
  - State encodings ST_IDLE=2'b00, ST_SCAN=2'b01, ST_DONE=2'b10.
  - NUM_CH=4.
  - Channel index width CHW=2.
  - Default SETTLE and CW.
- One natural sub-module: mux_scan_timer.
  - Loadable CW-bit down-counter: inputs load, value, en; output zero.
  - Used for the per-channel settle count.
- FSM, channel counter and shadow/word registers stay in mux_scan_ctrl.

Test Plan:
- Reset then idle: assert reset for 3 cycles, release, hold start=0 for 10 cycles -> s1=s2=0, valid=0, busy=0, word=4'b0000 throughout.
- Basic scan: SETTLE=1, model mux with a=1,b=0,c=1,d=0, pulse start, ready=1 -> select sequence {s2,s1}=00,00,01,01,10,10,11,11; valid is high for exactly one cycle, 8 cycles after start, with word=4'b0101.
- Back-pressure: same data, ready=0 for 5 cycles after valid, then 1 -> valid and word=4'b0101 stable all 5 cycles; start pulses during the scan are ignored; busy drops the cycle after ready.
- Back-to-back: hold start=1 and ready=1 with data changed to a=0,b=1,c=1,d=1 after the first word -> second scan begins on the handshake edge with no IDLE cycle; second word=4'b1110.
- SETTLE=0: rebuild with SETTLE=0 and data a=1,b=1,c=0,d=1 -> each select held one cycle; valid 4 cycles after start; word=4'b1011.
- Async reset mid-operation: assert reset between clock edges during channel 2 -> outputs clear immediately, with no valid pulse; a later start yields a correct full scan.

Source files
------------

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the 4-channel mux scan controller.
package mux_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int NUM_CH     = 4;
    localparam int CHW        = 2;
    localparam int DEF_SETTLE = 1;
    localparam int DEF_CW     = 4;

endpackage

// File: rtl/mux_scan_timer.sv
// Loadable down-counter used to time the settle window on each mux channel.
module mux_scan_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] value,
    output logic          zero
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through channels 0..3, samples e after each settle
// window and hands the assembled 4-bit word downstream via valid/ready.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int SETTLE = DEF_SETTLE,
    parameter int CW     = DEF_CW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       e,
    output logic       s1,
    output logic       s2,
    output logic [3:0] word,
    output logic       valid,
    input  logic       ready,
    output logic       busy
);

    localparam logic [CW-1:0] SETTLE_V = CW'(SETTLE);
    localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);

    state_e            state_q, state_d;
    logic [CHW-1:0]    ch_q, ch_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [3:0]        word_q, word_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              tmr_load, tmr_en, tmr_zero;

    mux_scan_timer #(.CW(CW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .en    (tmr_en),
        .value (SETTLE_V),
        .zero  (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        word_d   = word_q;
        valid_d  = valid_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SCAN;
                    ch_d     = '0;
                    tmr_load = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!tmr_zero) begin
                    tmr_en = 1'b1;
                end else begin
                    shadow_d[ch_q] = e;
                    if (ch_q == LAST_CH) begin
                        // Last sample goes straight into word; shadow holds the rest.
                        word_d  = {e, shadow_q[NUM_CH-2:0]};
                        valid_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        ch_d     = ch_q + CHW'(1);
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (ready) begin
                    valid_d = 1'b0;
                    ch_d    = '0;
                    if (start) begin
                        state_d  = ST_SCAN;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ch_d    = '0;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == ST_SCAN) || (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            shadow_q <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign s1    = ch_q[0];
    assign s2    = ch_q[1];
    assign word  = word_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: instance 0 uses SETTLE=1, instance 1 uses SETTLE=0.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0] start_v, ready_v;
    logic [3:0] data_v [2];
    wire  [1:0] e_v, s1_v, s2_v, valid_v, busy_v;
    wire  [3:0] word0, word1;

    // Behavioural 4x1 mux: data bit i is channel i (a,b,c,d = bits 0..3).
    assign e_v[0] = data_v[0][{s2_v[0], s1_v[0]}];
    assign e_v[1] = data_v[1][{s2_v[1], s1_v[1]}];

    mux_scan_ctrl #(.SETTLE(1), .CW(4)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .e(e_v[0]),
        .s1(s1_v[0]), .s2(s2_v[0]), .word(word0), .valid(valid_v[0]),
        .ready(ready_v[0]), .busy(busy_v[0])
    );

    mux_scan_ctrl #(.SETTLE(0), .CW(4)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .e(e_v[1]),
        .s1(s1_v[1]), .s2(s2_v[1]), .word(word1), .valid(valid_v[1]),
        .ready(ready_v[1]), .busy(busy_v[1])
    );

    int total = 0;
    int bad   = 0;
    logic [3:0] last_word [2];

    typedef struct {
        int         which;
        logic [3:0] data;
        int         delay;
        logic [3:0] exp_word;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int selof(input int w);
        return int'({s2_v[w], s1_v[w]});
    endfunction

    function automatic int wordof(input int w);
        return (w == 0) ? int'(word0) : int'(word1);
    endfunction

    task automatic check_idle(input int w, input string tag);
        chk({tag, "_sel"},   selof(w), 0);
        chk({tag, "_valid"}, valid_v[w], 0);
        chk({tag, "_busy"},  busy_v[w], 0);
        chk({tag, "_word"},  wordof(w), last_word[w]);
    endtask

    // One full scan with checks on select timing, latency, hold and handshake.
    task automatic run_scan(input int w, input logic [3:0] data, input int delay,
                            input string tag);
        int S;
        int L;
        logic [3:0] expw;
        S = (w == 0) ? 1 : 0;
        L = 4 * (S + 1);
        for (int i = 0; i < 4; i++) expw[i] = data[i];
        data_v[w]  = data;
        ready_v[w] = (delay == 0);
        start_v[w] = 1'b1;
        for (int j = 1; j <= L; j++) begin
            tick();
            if (j == 1) start_v[w] = 1'b0;
            if (j == 2) start_v[w] = 1'b1;
            if (j == 3) start_v[w] = 1'b0;
            chk({tag, "_scan_sel"},   selof(w), (j - 1) / (S + 1));
            chk({tag, "_scan_valid"}, valid_v[w], 0);
            chk({tag, "_scan_busy"},  busy_v[w], 1);
            chk({tag, "_scan_word"},  wordof(w), last_word[w]);
        end
        tick();
        chk({tag, "_valid_rise"}, valid_v[w], 1);
        chk({tag, "_word"},       wordof(w), expw);
        chk({tag, "_done_sel"},   selof(w), 3);
        chk({tag, "_done_busy"},  busy_v[w], 1);
        last_word[w] = expw;
        for (int k = 0; k < delay; k++) begin
            tick();
            chk({tag, "_hold_valid"}, valid_v[w], 1);
            chk({tag, "_hold_word"},  wordof(w), expw);
        end
        ready_v[w] = 1'b1;
        tick();
        check_idle(w, {tag, "_post"});
        ready_v[w] = 1'b0;
    endtask

    initial begin
        start_v   = '0;
        ready_v   = '0;
        data_v[0] = '0;
        data_v[1] = '0;
        last_word[0] = '0;
        last_word[1] = '0;
        reset = 1'b1;

        tv[0] = '{0, 4'b0101, 0, 4'b0101};
        tv[1] = '{0, 4'b0101, 5, 4'b0101};
        tv[2] = '{1, 4'b1011, 0, 4'b1011};
        tv[3] = '{0, 4'b0000, 2, 4'b0000};
        tv[4] = '{1, 4'b1111, 3, 4'b1111};
        tv[5] = '{0, 4'b1110, 1, 4'b1110};

        for (int c = 0; c < 3; c++) begin
            tick();
            check_idle(0, "rst0");
            check_idle(1, "rst1");
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_idle(0, "idle0");
            check_idle(1, "idle1");
        end

        for (int t = 0; t < 6; t++) begin
            run_scan(tv[t].which, tv[t].data, tv[t].delay, "vec");
            chk("vec_table_word", wordof(tv[t].which), tv[t].exp_word);
        end

        // Back-to-back: handshake edge starts the next scan with no IDLE bubble.
        data_v[0]  = 4'b0101;
        start_v[0] = 1'b1;
        ready_v[0] = 1'b1;
        for (int j = 1; j <= 8; j++) tick();
        tick();
        chk("b2b_valid1", valid_v[0], 1);
        chk("b2b_word1",  word0, 4'b0101);
        data_v[0] = 4'b1110;
        tick();
        chk("b2b_no_bubble_busy",  busy_v[0], 1);
        chk("b2b_no_bubble_valid", valid_v[0], 0);
        chk("b2b_no_bubble_sel",   selof(0), 0);
        start_v[0] = 1'b0;
        for (int j = 2; j <= 8; j++) begin
            tick();
            chk("b2b_sel",  selof(0), (j - 1) / 2);
            chk("b2b_hold", word0, 4'b0101);
        end
        tick();
        chk("b2b_valid2", valid_v[0], 1);
        chk("b2b_word2",  word0, 4'b1110);
        last_word[0] = 4'b1110;
        tick();
        check_idle(0, "b2b_end");
        ready_v[0] = 1'b0;

        // Async reset during channel 2 of a scan.
        data_v[0]  = 4'b1111;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int j = 2; j <= 5; j++) tick();
        chk("arst_pre_sel", selof(0), 2);
        #2;
        reset = 1'b1;
        #1;
        last_word[0] = '0;
        last_word[1] = '0;
        check_idle(0, "arst_now0");
        check_idle(1, "arst_now1");
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_idle(0, "arst_after");
        end
        run_scan(0, 4'b0110, 1, "arst_rescan");

        // Randomized scans against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            int w;
            int gap;
            w   = int'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                tick();
                check_idle(w, "rnd_gap");
            end
            run_scan(w, 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
